// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle control FSM (master) and the datapath (slave).
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       alu_branch;
  logic       mem_ready;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic [1:0] aluop;
  logic       alusrc;
  logic [1:0] alu_a_sel;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       retire;
  logic       illegal;
  logic       timeout;
  logic [2:0] state;

  modport master (
    input  opcode, alu_branch, mem_ready,
    output ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_sel,
           aluop, alusrc, alu_a_sel, reg_write, wb_sel, retire,
           illegal, timeout, state
  );

  modport slave (
    output opcode, alu_branch, mem_ready,
    input  ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_sel,
           aluop, alusrc, alu_a_sel, reg_write, wb_sel, retire,
           illegal, timeout, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/exec/mem/writeback over a
// shared ALU and memory port, halting on unsupported opcodes or memory stalls past STALL_LIMIT.
module multicycle_ctrl #(
  parameter int unsigned STALL_LIMIT = 255
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);
  localparam int unsigned   CW       = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STALL_LIMIT - 1);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic [2:0]    state_q, state_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       ir_write_c, pc_write_c, mem_req_c, mem_we_c, mem_addr_sel_c;
  logic       alusrc_c, reg_write_c, retire_c;
  logic [1:0] pc_src_c, aluop_c, alu_a_sel_c, wb_sel_c;
  logic       is_legal, is_store;

  assign is_store = (bus.opcode == OP_STORE);
  assign is_legal = (bus.opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI,
                                        OP_AUIPC, OP_BR, OP_JAL, OP_JALR});

  always_comb begin
    state_d        = state_q;
    illegal_d      = illegal_q;
    timeout_d      = timeout_q;
    ir_write_c     = 1'b0;
    pc_write_c     = 1'b0;
    pc_src_c       = 2'b00;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    aluop_c        = 2'b00;
    alusrc_c       = 1'b0;
    alu_a_sel_c    = 2'b00;
    reg_write_c    = 1'b0;
    wb_sel_c       = 2'b00;
    retire_c       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        case (bus.opcode)
          OP_R: begin
            aluop_c = 2'b10;
            state_d = S_WB;
          end
          OP_I: begin
            aluop_c  = 2'b11;
            alusrc_c = 1'b1;
            state_d  = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alusrc_c = 1'b1;
            state_d  = S_MEM;
          end
          OP_LUI, OP_AUIPC: begin
            alusrc_c    = 1'b1;
            alu_a_sel_c = (bus.opcode == OP_LUI) ? 2'b10 : 2'b01;
            state_d     = S_WB;
          end
          OP_BR: begin
            aluop_c    = 2'b01;
            pc_write_c = 1'b1;
            pc_src_c   = bus.alu_branch ? 2'b01 : 2'b00;
            retire_c   = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JAL, OP_JALR: begin
            alusrc_c    = (bus.opcode == OP_JALR);
            reg_write_c = 1'b1;
            wb_sel_c    = 2'b10;
            pc_write_c  = 1'b1;
            pc_src_c    = (bus.opcode == OP_JALR) ? 2'b10 : 2'b01;
            retire_c    = 1'b1;
            state_d     = S_FETCH;
          end
          default: begin
            // IR is supposed to be stable after DECODE; treat a change as illegal.
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = is_store;
        if (bus.mem_ready) begin
          if (is_store) begin
            pc_write_c = 1'b1;
            retire_c   = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        wb_sel_c    = (bus.opcode == OP_LOAD) ? 2'b01 : 2'b00;
        pc_write_c  = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_HALT;
    endcase

    // Counts consecutive stalled cycles of one access; non-memory states leave it at zero.
    if (mem_req_c && !bus.mem_ready && (state_d == state_q)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.ir_write     = ir_write_c & ~rst;
  assign bus.pc_write     = pc_write_c & ~rst;
  assign bus.pc_src       = rst ? 2'b00 : pc_src_c;
  assign bus.mem_req      = mem_req_c & ~rst;
  assign bus.mem_we       = mem_we_c & ~rst;
  assign bus.mem_addr_sel = mem_addr_sel_c & ~rst;
  assign bus.aluop        = rst ? 2'b00 : aluop_c;
  assign bus.alusrc       = alusrc_c & ~rst;
  assign bus.alu_a_sel    = rst ? 2'b00 : alu_a_sel_c;
  assign bus.reg_write    = reg_write_c & ~rst;
  assign bus.wb_sel       = rst ? 2'b00 : wb_sel_c;
  assign bus.retire       = retire_c & ~rst;
  assign bus.illegal      = illegal_q;
  assign bus.timeout      = timeout_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a directed vector table, hand-built corner sequences and random
// instructions, each expanded cycle by cycle from the instruction-level rules into expectations.
module tb_multicycle_ctrl;
  localparam int LIM = 4;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [2:0] FE = 3'd0, DE = 3'd1, EX = 3'd2, ME = 3'd3, WB = 3'd4, HA = 3'd5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl #(.STALL_LIMIT(LIM)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Field order: st ir pcw pcsrc req we asel aluop alusrc a_sel rw wbsel ret ill to
  typedef struct packed {
    logic [2:0] st;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic [1:0] aluop;
    logic       alusrc;
    logic [1:0] alu_a_sel;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       retire;
    logic       illegal;
    logic       timeout;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [6:0] opc;
    logic       br;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  vec_t  q[$];
  vec_t  tbl[10];
  logic  m_ill = 1'b0;
  logic  m_to = 1'b0;
  int    halt_n = 2;
  logic [6:0] ops[9] = '{OP_R, OP_I, OP_LD, OP_ST, OP_LUI, OP_AUI, OP_BR, OP_JAL, OP_JALR};

  function automatic outs_t actual();
    outs_t o;
    o.st = bus.state;            o.ir_write = bus.ir_write;   o.pc_write = bus.pc_write;
    o.pc_src = bus.pc_src;       o.mem_req = bus.mem_req;     o.mem_we = bus.mem_we;
    o.mem_addr_sel = bus.mem_addr_sel; o.aluop = bus.aluop;   o.alusrc = bus.alusrc;
    o.alu_a_sel = bus.alu_a_sel; o.reg_write = bus.reg_write; o.wb_sel = bus.wb_sel;
    o.retire = bus.retire;       o.illegal = bus.illegal;     o.timeout = bus.timeout;
    return o;
  endfunction

  function automatic outs_t z(input logic [2:0] s);
    outs_t o = '0;
    o.st = s;
    return o;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    outs_t a;
    rst = v.rst;
    bus.opcode = v.opc;
    bus.alu_branch = v.br;
    bus.mem_ready = v.rdy;
    #4;
    a = actual();
    checks++;
    if (a !== v.exp) begin
      failures++;
      $display("FAIL %s: outputs got=%h expected=%h (state got=%0d expected=%0d)",
               tag, a, v.exp, a.st, v.exp.st);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_q(input string tag);
    while (q.size() > 0) apply(q.pop_front(), tag);
  endtask

  task automatic push(input logic r, input logic [6:0] opc, input logic br, input logic rdy,
                      input outs_t e);
    vec_t v;
    e.illegal = m_ill;
    e.timeout = m_to;
    v.rst = r; v.opc = opc; v.br = br; v.rdy = rdy; v.exp = e;
    q.push_back(v);
  endtask

  // Parked in HALT for halt_n cycles with random inputs, then a reset cycle restarts at FETCH.
  task automatic halt_and_reset(input logic [6:0] opc);
    for (int i = 0; i < halt_n; i++) push(1'b0, opc, 1'($urandom), 1'($urandom), z(HA));
    push(1'b1, opc, 1'b0, 1'($urandom), z(HA));
    m_ill = 1'b0;
    m_to = 1'b0;
  endtask

  // n stalled cycles of a memory access; reaching LIM of them ends in a timeout halt.
  task automatic mem_wait(input logic [6:0] opc, input logic [2:0] s, input int n, output bit ok);
    outs_t e = z(s);
    e.mem_req = 1'b1;
    e.mem_addr_sel = (s == ME);
    e.mem_we = (s == ME) && (opc == OP_ST);
    ok = 1'b1;
    for (int i = 0; i < n && i < LIM; i++) push(1'b0, opc, 1'($urandom), 1'b0, e);
    if (n >= LIM) begin
      m_to = 1'b1;
      halt_and_reset(opc);
      ok = 1'b0;
    end
  endtask

  task automatic gen_instr(input logic [6:0] opc, input logic br, input int fw, input int mw);
    outs_t e;
    bit    ok;
    $display("instr opcode=%b branch=%0d fetch_wait=%0d mem_wait=%0d", opc, br, fw, mw);
    mem_wait(opc, FE, fw, ok);
    if (!ok) return;
    e = z(FE); e.mem_req = 1'b1; e.ir_write = 1'b1;
    push(1'b0, opc, br, 1'b1, e);
    push(1'b0, opc, br, 1'($urandom), z(DE));
    if (!(opc inside {OP_R, OP_I, OP_LD, OP_ST, OP_LUI, OP_AUI, OP_BR, OP_JAL, OP_JALR})) begin
      m_ill = 1'b1;
      halt_and_reset(opc);
      return;
    end
    e = z(EX);
    case (opc)
      OP_R:                  e.aluop = 2'b10;
      OP_I:                  begin e.aluop = 2'b11; e.alusrc = 1'b1; end
      OP_LD, OP_ST, OP_JALR: e.alusrc = 1'b1;
      OP_LUI:                begin e.alusrc = 1'b1; e.alu_a_sel = 2'b10; end
      OP_AUI:                begin e.alusrc = 1'b1; e.alu_a_sel = 2'b01; end
      OP_BR:                 begin e.aluop = 2'b01; e.pc_src = br ? 2'b01 : 2'b00; end
      default: ;
    endcase
    if (opc inside {OP_BR, OP_JAL, OP_JALR}) begin
      e.pc_write = 1'b1;
      e.retire = 1'b1;
      if (opc != OP_BR) begin
        e.reg_write = 1'b1;
        e.wb_sel = 2'b10;
        e.pc_src = (opc == OP_JAL) ? 2'b01 : 2'b10;
      end
      push(1'b0, opc, br, 1'($urandom), e);
      return;
    end
    push(1'b0, opc, br, 1'($urandom), e);
    if (opc inside {OP_LD, OP_ST}) begin
      mem_wait(opc, ME, mw, ok);
      if (!ok) return;
      e = z(ME); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
      if (opc == OP_ST) begin
        e.mem_we = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1;
        push(1'b0, opc, br, 1'b1, e);
        return;
      end
      push(1'b0, opc, br, 1'b1, e);
    end
    e = z(WB); e.reg_write = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1;
    e.wb_sel = (opc == OP_LD) ? 2'b01 : 2'b00;
    push(1'b0, opc, br, 1'($urandom), e);
  endtask

  function automatic int pick_wait();
    int r = $urandom_range(0, 9);
    if (r < 6) return 0;
    if (r < 9) return $urandom_range(1, 3);
    return $urandom_range(4, 5);
  endfunction

  initial begin
    vec_t  rv;
    logic [6:0] opc;

    // R-type, taken branch and JALR back to back with zero-wait memory.
    tbl[0] = '{1'b0, OP_R,    1'b0, 1'b1, outs_t'(21'b000_1_0_00_1_0_0_00_0_00_0_00_0_0_0)};
    tbl[1] = '{1'b0, OP_R,    1'b0, 1'b0, outs_t'(21'b001_0_0_00_0_0_0_00_0_00_0_00_0_0_0)};
    tbl[2] = '{1'b0, OP_R,    1'b0, 1'b1, outs_t'(21'b010_0_0_00_0_0_0_10_0_00_0_00_0_0_0)};
    tbl[3] = '{1'b0, OP_R,    1'b0, 1'b0, outs_t'(21'b100_0_1_00_0_0_0_00_0_00_1_00_1_0_0)};
    tbl[4] = '{1'b0, OP_BR,   1'b1, 1'b1, outs_t'(21'b000_1_0_00_1_0_0_00_0_00_0_00_0_0_0)};
    tbl[5] = '{1'b0, OP_BR,   1'b1, 1'b1, outs_t'(21'b001_0_0_00_0_0_0_00_0_00_0_00_0_0_0)};
    tbl[6] = '{1'b0, OP_BR,   1'b1, 1'b0, outs_t'(21'b010_0_1_01_0_0_0_01_0_00_0_00_1_0_0)};
    tbl[7] = '{1'b0, OP_JALR, 1'b0, 1'b1, outs_t'(21'b000_1_0_00_1_0_0_00_0_00_0_00_0_0_0)};
    tbl[8] = '{1'b0, OP_JALR, 1'b0, 1'b1, outs_t'(21'b001_0_0_00_0_0_0_00_0_00_0_00_0_0_0)};
    tbl[9] = '{1'b0, OP_JALR, 1'b0, 1'b1, outs_t'(21'b010_0_1_10_0_0_0_00_1_00_1_10_1_0_0)};

    rst = 1'b1;
    bus.opcode = 7'd0;
    bus.alu_branch = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rv = '{1'b1, OP_R, 1'b0, 1'b1, z(FE)};
    apply(rv, "reset");

    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("table%0d", i));

    gen_instr(OP_BR, 1'b0, 0, 0);  run_q("branch_not_taken");
    gen_instr(OP_LD, 1'b0, 0, 2);  run_q("load_2wait");
    gen_instr(OP_ST, 1'b0, 1, 1);  run_q("store_wait");
    gen_instr(OP_JAL, 1'b0, 0, 0); run_q("jal");
    gen_instr(OP_LUI, 1'b0, 2, 0); run_q("lui");
    gen_instr(OP_AUI, 1'b0, 0, 0); run_q("auipc");
    gen_instr(OP_I, 1'b0, 0, 0);   run_q("i_arith");
    halt_n = 10;
    gen_instr(7'b0000000, 1'b0, 0, 0); run_q("illegal_halt");
    halt_n = 2;
    gen_instr(OP_R, 1'b0, 0, 0);     run_q("after_illegal");
    gen_instr(OP_R, 1'b0, LIM, 0);   run_q("fetch_timeout");
    gen_instr(OP_R, 1'b0, LIM-1, 0); run_q("fetch_ready_last");
    gen_instr(OP_ST, 1'b0, 0, LIM);  run_q("mem_timeout");
    gen_instr(OP_LD, 1'b0, 0, LIM-1); run_q("mem_ready_last");

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 15) == 0) opc = 7'($urandom);
      else opc = ops[$urandom_range(0, 8)];
      gen_instr(opc, 1'($urandom), pick_wait(), pick_wait());
      run_q($sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multicycle RV32I core. It sequences one shared ALU and one shared memory port across fetch, decode, execute, memory and writeback states. It decodes the instruction-register opcode into the ALU's `aluop`/`alusrc` encoding and operand-A select. It also generates PC, IR, register-file and memory strobes, and halts on illegal opcodes or memory stalls that exceed a limit.

## Interface
Parameters:
- `STALL_LIMIT`, 255: consecutive non-ready memory cycles tolerated before a timeout halt; legal range 1..65535.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  7  IR[6:0]; valid from DECODE onward.
- `alu_branch`  in  1  branch compare result from ALU.
- `mem_ready`  in  1  memory access completes this cycle.
- `ir_write`  out  1  load IR from memory read data.
- `pc_write`  out  1  update PC.
- `pc_src`  out  2  00 pc+4, 01 pc+imm (target adder), 10 alu_result & ~1.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  store (valid with `mem_req`).
- `mem_addr_sel`  out  1  0 PC, 1 ALU-out register.
- `aluop`  out  2  00 add, 01 B-type, 10 R-type, 11 I-type.
- `alusrc`  out  1  0 rs2, 1 immediate.
- `alu_a_sel`  out  2  00 rs1, 01 PC, 10 zero.
- `reg_write`  out  1  register-file write enable.
- `wb_sel`  out  2  00 ALU-out register, 01 memory data, 10 pc+4.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `illegal`  out  1  sticky: unsupported opcode.
- `timeout`  out  1  sticky: memory stall limit hit.
- `state`  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.

## Operation
- The datapath latches the ALU result into the ALU-out register at every EXEC edge.
- All strobes not listed for a state are 0. Defaults: `aluop`=00, `alusrc`=0, `alu_a_sel`=00, `pc_src`=00, `wb_sel`=00.
- FETCH: `mem_req`=1, `mem_addr_sel`=0.
  - If `mem_ready`: `ir_write`=1, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle. Supported opcode → EXEC. Anything else → HALT with `illegal` set.
- EXEC, per opcode:
  - R 0110011: `aluop`=10, `alusrc`=0 → WB.
  - I-arith 0010011: `aluop`=11, `alusrc`=1 → WB.
  - LOAD 0000011 / STORE 0100011: `aluop`=00, `alusrc`=1 → MEM.
  - LUI 0110111: `aluop`=00, `alusrc`=1, `alu_a_sel`=10 → WB.
  - AUIPC 0010111: `aluop`=00, `alusrc`=1, `alu_a_sel`=01 → WB.
  - BRANCH 1100011: `aluop`=01, `alusrc`=0, `pc_write`=1, `pc_src`=01 if `alu_branch` else 00, `retire`=1 → FETCH.
  - JAL 1101111: `reg_write`=1, `wb_sel`=10, `pc_write`=1, `pc_src`=01, `retire`=1 → FETCH.
  - JALR 1100111: `aluop`=00, `alusrc`=1, `reg_write`=1, `wb_sel`=10, `pc_write`=1, `pc_src`=10, `retire`=1 → FETCH.
- MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for STORE.
  - On `mem_ready`, LOAD → WB.
  - On `mem_ready`, STORE: `pc_write`=1, `pc_src`=00, `retire`=1 → FETCH.
- WB: `reg_write`=1, `wb_sel`=01 for LOAD else 00, `pc_write`=1, `pc_src`=00, `retire`=1 → FETCH.
- The PC changes only when an instruction completes, so AUIPC and branch targets always use the instruction's own PC.
- HALT: all strobes 0; `state` holds until `rst`.
- Stall counter, width clog2(STALL_LIMIT+1):
  - Cleared on entry to FETCH/MEM and on any `mem_ready`.
  - Increments each cycle with `mem_req`=1 and `mem_ready`=0.
  - A non-ready cycle with counter = STALL_LIMIT-1 → HALT, `timeout`=1.
  - `mem_ready` in that same cycle wins: normal transition, no timeout.

## Timing
- Reset:
  - While `rst`=1, all strobes (`ir_write`, `pc_write`, `mem_req`, `mem_we`, `reg_write`, `retire`) are forced to 0.
  - At the reset edge: `state`=FETCH, `illegal`=0, `timeout`=0, counter=0.
  - After the reset edge, `mem_req`=1 immediately.
- Reset mid-instruction, including in HALT: abandons the instruction; no strobe fires in the `rst` cycle.
- Outputs are decoded combinationally from `state`, `opcode`, `alu_branch` and `mem_ready`. `ir_write`, `pc_write`, `retire` and `mem_we`-completion are same-cycle Mealy on `mem_ready`.
- Latency with zero-wait memory:
  - Branch/JAL/JALR: 3 cycles.
  - R/I/LUI/AUIPC: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each non-ready memory cycle adds 1.
- `retire` coincides exactly with the final `pc_write` of each instruction; exactly one pulse per instruction.

## Test plan
- Reset, opcode 0110011, `mem_ready`=1: `state` sequence 0,1,2,4,0. In EXEC `aluop`=10, `alusrc`=0. In WB `reg_write`=`pc_write`=`retire`=1, `pc_src`=00.
- LOAD with `mem_ready` low 2 cycles in MEM: sequence 0,1,2,3,3,3,4,0 (7 cycles). `mem_we`=0 throughout. In WB `wb_sel`=01.
- BRANCH with `alu_branch`=1: EXEC `aluop`=01, `pc_src`=01, `pc_write`=1, back to FETCH after 3 cycles. With `alu_branch`=0: `pc_src`=00.
- JALR: EXEC `aluop`=00, `alusrc`=1, `reg_write`=1, `wb_sel`=10, `pc_src`=10, `retire`=1, then FETCH.
- Opcode 0000000: DECODE → HALT, `illegal`=1; all strobes stay 0 for 10 cycles. Asserting `rst` clears `illegal` and restarts at FETCH.
- `STALL_LIMIT`=4, `mem_ready`=0 in FETCH: HALT after 4 cycles with `timeout`=1. Rerun with `mem_ready`=1 on the 4th cycle: DECODE, `timeout`=0.
